instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and instruction-memory loader for the pipelined core: the inverse of the control/decode path. It accepts a stream of decoded instruction descriptors over a valid/ready handshake. For each one it packs opcode, funct3, funct7 bit 5, registers and the class-specific immediate layout into a 32-bit word. It then writes that word into consecutive instruction-memory addresses. Benches and the boot path use it to build programs without hand-assembled hex.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the instruction-memory write port.
- CNT_W, 16, width of the instruction count.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; captured on start.
- count  in  CNT_W  number of instructions to accept; captured on start.
- in_valid  in  1  a descriptor is present.
- in_ready  out  1  the encoder accepts the descriptor this cycle.
- in_cls  in  3  instruction class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL; 6 and 7 are illegal.
- in_funct3  in  3  funct3 field.
- in_funct7b5  in  1  funct7 bit 5; used for R, and for I-ALU when funct3 is 101.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte-offset or immediate.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  ADDR_W  write byte address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky error flag; cleared on start.

## Operation
FSM states are IDLE, RUN and DONE.
- IDLE: start moves to RUN, loads base_addr into the address counter, loads count into the remaining counter and clears err. If count == 0, the FSM goes to DONE instead of RUN.
- RUN: in_ready = 1. An accepted beat is one where in_valid and in_ready are both high.
  - Each accepted beat is encoded and registered to the output stage.
  - The address advances by 4 and the remaining count decrements by 1.
  - On the beat that takes remaining to 0, the FSM moves to DONE.
- DONE: done = 1 for one cycle, then the FSM returns to IDLE.
- start is ignored outside IDLE.

Encoding uses the opcode constants R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, J 1101111.
- R: funct7 = {0, funct7b5, 00000}.
- I-ALU: when funct3 is 101, imm[11:5] is forced to {0, funct7b5, 00000}.
- B and J: imm[0] is not encoded.

Errors. On any of the following, err is set and the word written is replaced by the NOP 0x00000013, at the same address; the beat is still consumed.
- Illegal class (6 or 7).
- Immediate out of range: I/L/S outside [-2048, 2047], B outside [-4096, 4094], J outside [-1048576, 1048574].
- Odd immediate for B or J.

The address counter wraps modulo 2^ADDR_W without flagging.

## Timing
Reset values:
- Outputs: in_ready, imem_we, busy, done and err are 0; imem_waddr and imem_wdata are 0.
- FSM is in IDLE.

Latency and throughput:
- A beat accepted in cycle N produces imem_we = 1 in cycle N+1, with imem_waddr and imem_wdata registered.
- Throughput is one instruction per cycle; in_valid gaps produce imem_we = 0 cycles.

DONE timing:
- The FSM enters DONE in cycle N+1 after the last accept in cycle N, so done coincides with the final imem_we.
- When count == 0, done is asserted in the cycle after start and no write occurs.

Reset:
- Asserting rst_n low mid-load drops imem_we and done immediately.
- A pending output write is discarded and no partial state survives.

## Structure
- The shared package `rv_isa_pkg` holds:
  - the opcode localparams;
  - the class enum;
  - the NOP constant;
  - the immediate range limits.
- The decode side also uses this package.
- Combinational packing goes in one sub-module, `instr_field_pack`: descriptor in, {word, illegal} out.
- The FSM, counters and output register stay in the top module.

## Test plan
- start, base 0x100, count 3; send add x3,x1,x2, then sub x3,x1,x2, then addi x1,x0,5 -> writes of 0x002081B3 @0x100, 0x402081B3 @0x104 and 0x00500093 @0x108; done on the cycle of the 0x108 write.
- lw x2,4(x1) then sw x2,8(x1) -> 0x0040A103, then 0x0020A423.
- beq x1,x2,imm=-4 -> 0xFE208EE3; the same descriptor with imm=-3 -> 0x00000013 written and err = 1, held until the next start.
- count 0 -> done one cycle after start, with no imem_we.
- in_valid toggling every other cycle, count 4 -> four writes at consecutive addresses; in_ready = 0 after the last accept.
- rst_n pulled low on the cycle after the second accept of a count-5 load -> no further writes, all outputs 0; a new start behaves normally.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I ISA constants shared by the encode and decode paths.
// Opcodes, instruction classes, NOP word and immediate limits.
package rv_isa_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  typedef enum logic [2:0] {
    CLS_R = 3'd0,
    CLS_I = 3'd1,
    CLS_L = 3'd2,
    CLS_S = 3'd3,
    CLS_B = 3'd4,
    CLS_J = 3'd5
  } cls_e;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  function automatic logic in_range(
    input logic [31:0] v,
    input int          lo,
    input int          hi
  );
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packer.
// Illegal descriptors come out as the NOP word.
module instr_field_pack
  import rv_isa_pkg::*;
(
  input  desc_t       d,
  output logic [31:0] word,
  output logic        illegal
);

  logic [11:0] i_imm;
  logic [31:0] w;
  logic        bad;

  // shift-immediate form reuses imm[11:5] as funct7
  always_comb begin
    i_imm = d.imm[11:0];
    if (d.funct3 == 3'b101)
      i_imm[11:5] = {1'b0, d.f7b5, 5'b0};
  end

  // class decode, range checks and field layout
  always_comb begin
    w   = NOP;
    bad = 1'b0;
    unique case (1'b1)
      (d.cls == CLS_R): begin
        w = {1'b0, d.f7b5, 5'b0, d.rs2, d.rs1,
             d.funct3, d.rd, OP_R};
      end
      (d.cls == CLS_I): begin
        bad = !in_range(d.imm, IMM12_MIN, IMM12_MAX);
        w = {i_imm, d.rs1, d.funct3, d.rd, OP_I};
      end
      (d.cls == CLS_L): begin
        bad = !in_range(d.imm, IMM12_MIN, IMM12_MAX);
        w = {d.imm[11:0], d.rs1, d.funct3, d.rd, OP_L};
      end
      (d.cls == CLS_S): begin
        bad = !in_range(d.imm, IMM12_MIN, IMM12_MAX);
        w = {d.imm[11:5], d.rs2, d.rs1, d.funct3,
             d.imm[4:0], OP_S};
      end
      (d.cls == CLS_B): begin
        bad = !in_range(d.imm, IMMB_MIN, IMMB_MAX)
              || d.imm[0];
        w = {d.imm[12], d.imm[10:5], d.rs2, d.rs1,
             d.funct3, d.imm[4:1], d.imm[11], OP_B};
      end
      (d.cls == CLS_J): begin
        bad = !in_range(d.imm, IMMJ_MIN, IMMJ_MAX)
              || d.imm[0];
        w = {d.imm[20], d.imm[10:1], d.imm[11],
             d.imm[19:12], d.rd, OP_J};
      end
      default: bad = 1'b1;
    endcase
  end

  assign illegal = bad;
  assign word    = bad ? NOP : w;

endmodule

// File: rtl/instr_encoder.sv
// Streams decoded descriptors into consecutive
// instruction-memory words, one per cycle.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  desc_t             desc;
  logic [31:0]       word;
  logic              illegal;

  assign desc = '{
    cls:    in_cls,
    funct3: in_funct3,
    f7b5:   in_funct7b5,
    rd:     in_rd,
    rs1:    in_rs1,
    rs2:    in_rs2,
    imm:    in_imm
  };

  instr_field_pack u_pack (
    .d       (desc),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  // load FSM, address/remaining counters and write stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      rem        <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr  <= base_addr;
            rem   <= count;
            err   <= 1'b0;
            state <= (count == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            imem_we    <= 1'b1;
            imem_waddr <= addr;
            imem_wdata <= word;
            if (illegal)
              err <= 1'b1;
            addr <= addr + ADDR_W'(4);
            rem  <= rem - CNT_W'(1);
            if (rem == CNT_W'(1))
              state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed
// program loads plus randomized descriptor streams.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_cls = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          last;
    bit          err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_addr;
  int          m_left;
  bit          m_err;

  instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cls      (in_cls),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // reference encoder: RV32I rules written as field arithmetic
  function automatic logic [32:0] model(
    input int cls, input int f3, input int b5,
    input int rd, input int rs1, input int rs2,
    input int imm);
    logic [31:0] u, f, w, r;
    bit bad;
    u = imm; bad = 0; w = 0;
    r = (32'(rs1) << 15) | (32'(f3) << 12);
    case (cls)
      0: w = (32'(b5) << 30) | (32'(rs2) << 20) | r
             | (32'(rd) << 7) | 32'h33;
      1, 2: begin
        bad = imm < -2048 || imm > 2047;
        f = u & 32'hFFF;
        if (cls == 1 && f3 == 5)
          f = (f & 32'h1F) | (32'(b5) << 10);
        w = (f << 20) | r | (32'(rd) << 7)
            | ((cls == 1) ? 32'h13 : 32'h03);
      end
      3: begin
        bad = imm < -2048 || imm > 2047;
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
            | r | ((u & 32'h1F) << 7) | 32'h23;
      end
      4: begin
        bad = imm < -4096 || imm > 4094 || (imm % 2 != 0);
        w = (((u >> 12) & 1) << 31)
            | (((u >> 5) & 32'h3F) << 25)
            | (32'(rs2) << 20) | r
            | (((u >> 1) & 32'hF) << 8)
            | (((u >> 11) & 1) << 7) | 32'h63;
      end
      5: begin
        bad = imm < -1048576 || imm > 1048574
              || (imm % 2 != 0);
        w = (((u >> 20) & 1) << 31)
            | (((u >> 1) & 32'h3FF) << 21)
            | (((u >> 11) & 1) << 20)
            | (((u >> 12) & 32'hFF) << 12)
            | (32'(rd) << 7) | 32'h6F;
      end
      default: bad = 1;
    endcase
    if (bad) w = 32'h13;
    return {bad, w};
  endfunction

  // monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (q.size() == 0) begin
        chk("spurious_we", 32'(imem_we), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("waddr", imem_waddr, e.a);
        chk("wdata", imem_wdata, e.d);
        chk("done_with_write", 32'(done), 32'(e.last));
        chk("err_with_write", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic do_start(input logic [31:0] b,
                          input int n);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = b; count = 16'(n);
    m_addr = b; m_left = n; m_err = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // drive one descriptor until accepted; called #1 after a posedge
  task automatic send(input int cls, input int f3,
                      input int b5, input int rd,
                      input int rs1, input int rs2,
                      input int imm, input bit lit_en,
                      input logic [31:0] lit,
                      input bit lit_err, input bit push);
    int t;
    logic [32:0] m;
    exp_t e;
    in_valid = 1'b1;
    in_cls = 3'(cls); in_funct3 = 3'(f3);
    in_funct7b5 = b5[0]; in_rd = 5'(rd);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = imm;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (t >= 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      t++;
      @(posedge clk);
      #1;
    end
    m = model(cls, f3, b5, rd, rs1, rs2, imm);
    if (lit_en) m = {lit_err, lit};
    m_err = m_err | m[32];
    e.a = m_addr; e.d = m[31:0];
    e.last = (m_left == 1); e.err = m_err;
    if (push) q.push_back(e);
    m_addr = m_addr + 32'd4;
    m_left--;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    int cls, lim, imm, r;
    cls = ($urandom_range(0, 9) == 0)
          ? 6 + int'($urandom_range(0, 1))
          : int'($urandom_range(0, 5));
    lim = (cls == 4) ? 4096 : (cls == 5) ? 1048576 : 2048;
    r = int'($urandom_range(0, 9));
    if (r == 0)
      imm = lim + int'($urandom_range(0, 50));
    else if (r == 1)
      imm = -lim - 1 - int'($urandom_range(0, 50));
    else
      imm = int'($urandom_range(0, 2 * lim - 1)) - lim;
    if ((cls == 4 || cls == 5) && r != 2) imm = imm & ~1;
    send(cls, int'($urandom_range(0, 7)),
         int'($urandom_range(0, 1)),
         int'($urandom_range(0, 31)),
         int'($urandom_range(0, 31)),
         int'($urandom_range(0, 31)), imm,
         0, 32'd0, 0, 1);
  endtask

  task automatic rand_load(input logic [31:0] b);
    int n;
    n = int'($urandom_range(1, 8));
    do_start(b, n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0)
        idle(int'($urandom_range(1, 2)));
      rand_beat();
    end
  endtask

  initial begin
    #22;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_waddr", imem_waddr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1;

    // add, sub, addi
    do_start(32'h100, 3);
    send(0, 0, 0, 3, 1, 2, 0, 1, 32'h002081B3, 0, 1);
    send(0, 0, 1, 3, 1, 2, 0, 1, 32'h402081B3, 0, 1);
    send(1, 0, 0, 1, 0, 0, 5, 1, 32'h00500093, 0, 1);

    // lw, sw
    do_start(32'h200, 2);
    send(2, 2, 0, 2, 1, 0, 4, 1, 32'h0040A103, 0, 1);
    send(3, 2, 0, 0, 1, 2, 8, 1, 32'h0020A423, 0, 1);

    // beq -4 then odd offset
    do_start(32'h300, 2);
    send(4, 0, 0, 0, 1, 2, -4, 1, 32'hFE208EE3, 0, 1);
    send(4, 0, 0, 0, 1, 2, -3, 1, 32'h00000013, 1, 1);
    idle(4);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);

    // empty load
    do_start(32'h400, 0);
    @(negedge clk);
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_we", 32'(imem_we), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    chk("cnt0_done_pulse", 32'(done), 32'd0);

    // valid toggling every other cycle
    do_start(32'h500, 4);
    for (int i = 0; i < 4; i++) begin
      send(1, i % 8, 0, i + 1, i, 0, i * 7, 0, 32'd0, 0, 1);
      if (i != 3) idle(1);
    end
    @(negedge clk);
    chk("ready_after_last", 32'(in_ready), 32'd0);

    // address wrap
    do_start(32'hFFFF_FFF8, 4);
    for (int i = 0; i < 4; i++) rand_beat();

    // random loads
    for (int k = 0; k < 12; k++)
      rand_load($urandom() & 32'hFFFF_FFFC);

    // reset mid-load
    do_start(32'h600, 5);
    send(0, 0, 0, 5, 6, 7, 0, 0, 32'd0, 0, 1);
    send(0, 0, 1, 5, 6, 7, 0, 0, 32'd0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_waddr", imem_waddr, 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    @(negedge clk);
    chk("post_rst_we", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1;
    rand_load(32'h700);
    rand_load(32'h800);
    idle(4);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
